prod_accum: RTL and testbench
=============================

Name: prod_accum

Overview:
- Sequential stage directly downstream of the 8x8 combinational multiplier.
- Consumes its 16-bit product stream over a valid/ready handshake and sums products into a frame.
- A frame closes on in_last or after MAX_CNT beats.
- Presents the frame total, beat count and overflow flag on a held output handshake. This gives the multiplier a clocked dot-product back end.

Parameters:
- PROD_W, 16, width of incoming product (matches multiplier output).
- ACC_W, 24, accumulator/result width; must be >= PROD_W.
- MAX_CNT, 16, maximum beats per frame; frame auto-closes at this count.
- CNT_W, $clog2(MAX_CNT+1), derived width of beat counter (localparam).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  product beat present.
- in_ready  output  1  stage can accept a beat.
- in_prod  input  PROD_W  unsigned product from multiplier.
- in_last  input  1  beat is final of frame.
- out_valid  output  1  frame result available.
- out_ready  input  1  consumer takes result.
- out_sum  output  ACC_W  frame total.
- out_count  output  CNT_W  beats in frame (1..MAX_CNT).
- out_ovf  output  1  sum exceeded ACC_W bits at some point in frame.

Behaviour:
- Reset (async assert, sync-to-clk deassert by the system):
  - state=ACC; acc, count, ovf = 0.
  - out_valid=0, out_sum=0, out_count=0, out_ovf=0, in_ready=1.
- Two states: ACC, DONE.
- ACC state:
  - in_ready=1, out_valid=0.
  - Accept: in_valid&&in_ready at clk edge. On accept: acc <= acc + zero-extended in_prod; count <= count+1.
  - Overflow: if the (ACC_W+1)-bit sum carries out, ovf <= 1. ovf is sticky within the frame.
  - Close condition: accepted beat has in_last=1, or count+1==MAX_CNT. On close, go to DONE.
  - Idle cycles (in_valid=0): no change.
- DONE state:
  - in_ready=0; out_valid=1.
  - out_sum, out_count, out_ovf are registered and stable until the handshake.
  - On out_valid&&out_ready: acc, count, ovf cleared; go to ACC.
- Latency: result visible the cycle after the closing beat is accepted.
- Throughput: one beat per cycle in ACC. At least one bubble cycle per frame, since DONE always lasts >=1 cycle.
- out_ready held high: DONE lasts exactly 1 cycle.
- in_valid asserted during DONE: beat is not accepted. Upstream must hold in_prod/in_last until in_ready returns.
- in_last on the MAX_CNT-th beat: single close, no empty frame generated.
- Empty frames impossible: count is always >=1 at output.
- Wrap (default build): acc wraps modulo 2^ACC_W; out_ovf=1.
- Reset asserted mid-frame or in DONE: partial frame discarded; outputs return to reset values immediately (async).
- out_ready while not out_valid: ignored.

Optional Feature:
- Macro: PROD_ACCUM_SATURATE_EN.
- Defined: on carry-out, acc clamps to all-ones (2^ACC_W-1) and stays clamped for the rest of the frame. ovf still sets.
- Undefined: modular wrap as above.

Decomposition:
- Shared package prod_accum_pkg holds:
  - typedef enum logic [0:0] {ACC, DONE} accum_state_t
  - default width constants PROD_W_DEF=16, ACC_W_DEF=24
- One natural sub-module: accum_adder. It does the ACC_W add with carry-out and the optional saturation. It keeps the macro in one place.

Test Plan:
- Frame of products 100, 200, 300 (last on 300), out_ready=1 -> out_valid one cycle after third accept; out_sum=600, out_count=3, out_ovf=0.
- 16 beats of 0xFFFF, in_last never set -> auto-close; out_sum=0xFFFF0 (1048560), out_count=16, out_ovf=0; in_ready low for exactly 1 cycle.
- ACC_W=17, three beats 0xFFFF last on third -> wrap build: out_sum=65533, out_ovf=1. With PROD_ACCUM_SATURATE_EN: out_sum=0x1FFFF, out_ovf=1.
- Close frame {5,7}, hold out_ready=0 for 5 cycles while in_valid=1 with prod 9 -> in_ready=0, out_sum=12 stable throughout. After the handshake, 9 is accepted as beat 1 of the next frame.
- Accept 2 beats (10, 20), assert rst_n=0 mid-cycle -> outputs zero immediately. After release, frame {4} last -> out_sum=4, out_count=1.
- Back-to-back frames with continuous in_valid and out_ready=1: {1},{2},{3} each last -> three results 1, 2, 3 in order, each separated by one in_ready bubble.

Source files
------------

// File: rtl/prod_accum_pkg.sv
// Shared types and default widths for the product accumulator.
package prod_accum_pkg;

    typedef enum logic [0:0] {
        ACC  = 1'b0,
        DONE = 1'b1
    } accum_state_t;

    localparam int unsigned PROD_W_DEF = 16;
    localparam int unsigned ACC_W_DEF  = 24;

endpackage : prod_accum_pkg

// File: rtl/prod_accum_adder.sv
// accum_adder: ACC_W-wide accumulate step with carry-out.
// Optional build macro PROD_ACCUM_SATURATE_EN clamps the sum to all-ones on carry-out;
// otherwise the sum wraps modulo 2^ACC_W.
module accum_adder
    import prod_accum_pkg::*;
#(
    parameter int unsigned PROD_W = PROD_W_DEF,
    parameter int unsigned ACC_W  = ACC_W_DEF
) (
    input  logic [ACC_W-1:0]  i_acc,
    input  logic [PROD_W-1:0] i_prod,
    output logic [ACC_W-1:0]  o_sum_c,
    output logic              o_carry_c
);

    logic [ACC_W:0] w_full;

    // Widened add; the top bit is the carry-out. Once clamped, adding any
    // further product either carries again or adds zero, so the clamp holds.
    always_comb begin
        w_full    = {1'b0, i_acc} + (ACC_W+1)'(i_prod);
        o_carry_c = w_full[ACC_W];
`ifdef PROD_ACCUM_SATURATE_EN
        o_sum_c   = w_full[ACC_W] ? {ACC_W{1'b1}} : w_full[ACC_W-1:0];
`else
        o_sum_c   = w_full[ACC_W-1:0];
`endif
    end

endmodule : accum_adder

// File: rtl/prod_accum.sv
// prod_accum: sums a valid/ready stream of multiplier products into frames
// closed by in_last or by reaching MAX_CNT beats, and holds the frame total,
// beat count and overflow flag on an output handshake.
// Build macro PROD_ACCUM_SATURATE_EN selects saturating instead of wrapping sums.
module prod_accum
    import prod_accum_pkg::*;
#(
    parameter  int unsigned PROD_W  = PROD_W_DEF,
    parameter  int unsigned ACC_W   = ACC_W_DEF,
    parameter  int unsigned MAX_CNT = 16,
    localparam int unsigned CNT_W   = $clog2(MAX_CNT + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PROD_W-1:0] in_prod,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_sum,
    output logic [CNT_W-1:0]  out_count,
    output logic              out_ovf
);

    accum_state_t     r_state;
    accum_state_t     w_state_nxt;
    logic [ACC_W-1:0] r_acc;
    logic [ACC_W-1:0] w_acc_nxt;
    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] w_count_nxt;
    logic [CNT_W-1:0] w_count_inc;
    logic             r_ovf;
    logic             w_ovf_nxt;
    logic             r_out_valid;
    logic             w_out_valid_nxt;
    logic             r_in_ready;
    logic             w_in_ready_nxt;
    logic [ACC_W-1:0] w_sum;
    logic             w_carry;
    logic             w_accept;
    logic             w_close;

    accum_adder #(
        .PROD_W (PROD_W),
        .ACC_W  (ACC_W)
    ) u_adder (
        .i_acc     (r_acc),
        .i_prod    (in_prod),
        .o_sum_c   (w_sum),
        .o_carry_c (w_carry)
    );

    assign w_accept    = in_valid && r_in_ready;
    assign w_count_inc = r_count + CNT_W'(1);
    assign w_close     = in_last || (w_count_inc == CNT_W'(MAX_CNT));

    // State, datapath and handshake registers; acc/count/ovf double as held outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ACC;
            r_acc       <= '0;
            r_count     <= '0;
            r_ovf       <= 1'b0;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
        end else begin
            r_state     <= w_state_nxt;
            r_acc       <= w_acc_nxt;
            r_count     <= w_count_nxt;
            r_ovf       <= w_ovf_nxt;
            r_out_valid <= w_out_valid_nxt;
            r_in_ready  <= w_in_ready_nxt;
        end
    end

    // Next-state: accumulate accepted beats in ACC, hold the result in DONE until taken.
    always_comb begin
        w_state_nxt     = r_state;
        w_acc_nxt       = r_acc;
        w_count_nxt     = r_count;
        w_ovf_nxt       = r_ovf;
        w_out_valid_nxt = r_out_valid;
        w_in_ready_nxt  = r_in_ready;
        unique case (r_state)
            ACC: begin
                if (w_accept) begin
                    w_acc_nxt   = w_sum;
                    w_count_nxt = w_count_inc;
                    w_ovf_nxt   = r_ovf | w_carry;
                    if (w_close) begin
                        w_state_nxt     = DONE;
                        w_out_valid_nxt = 1'b1;
                        w_in_ready_nxt  = 1'b0;
                    end
                end
            end
            DONE: begin
                if (out_ready) begin
                    w_acc_nxt       = '0;
                    w_count_nxt     = '0;
                    w_ovf_nxt       = 1'b0;
                    w_state_nxt     = ACC;
                    w_out_valid_nxt = 1'b0;
                    w_in_ready_nxt  = 1'b1;
                end
            end
            default: begin
                w_state_nxt = ACC;
            end
        endcase
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_sum   = r_acc;
    assign out_count = r_count;
    assign out_ovf   = r_ovf;

endmodule : prod_accum

// File: tb/tb_prod_accum.sv
// Directed bench for prod_accum: default-width instance plus an ACC_W=17
// instance for the overflow case (expectation follows PROD_ACCUM_SATURATE_EN).
module tb_prod_accum;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_prod;
    logic        in_last;
    logic        out_valid;
    logic        out_ready;
    logic [23:0] out_sum;
    logic [4:0]  out_count;
    logic        out_ovf;

    logic        n_valid;
    logic        n_ready;
    logic [15:0] n_prod;
    logic        n_last;
    logic        n_out_valid;
    logic        n_out_ready;
    logic [16:0] n_sum;
    logic [4:0]  n_count;
    logic        n_ovf;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    prod_accum u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_prod   (in_prod),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_count (out_count),
        .out_ovf   (out_ovf)
    );

    prod_accum #(.ACC_W(17)) u_dut17 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (n_valid),
        .in_ready  (n_ready),
        .in_prod   (n_prod),
        .in_last   (n_last),
        .out_valid (n_out_valid),
        .out_ready (n_out_ready),
        .out_sum   (n_sum),
        .out_count (n_count),
        .out_ovf   (n_ovf)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Present a beat and return at the negedge after the edge that accepts it.
    task automatic beat(input logic [15:0] p, input logic l);
        int t;
        t = 0;
        in_valid = 1'b1;
        in_prod  = p;
        in_last  = l;
        while (in_ready !== 1'b1 && t < 20) begin
            @(negedge clk);
            t++;
        end
        chk("beat_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
    endtask

    initial begin
        rst_n       = 1'b0;
        in_valid    = 1'b0;
        in_prod     = '0;
        in_last     = 1'b0;
        out_ready   = 1'b0;
        n_valid     = 1'b0;
        n_prod      = '0;
        n_last      = 1'b0;
        n_out_ready = 1'b1;

        // Reset state
        @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_sum",   32'(out_sum),   32'd0);
        chk("rst_out_count", 32'(out_count), 32'd0);
        chk("rst_out_ovf",   32'(out_ovf),   32'd0);
        chk("rst_in_ready",  32'(in_ready),  32'd1);
        rst_n = 1'b1;
        @(negedge clk);

        // Frame {100,200,300}
        out_ready = 1'b1;
        beat(16'd100, 1'b0);
        beat(16'd200, 1'b0);
        beat(16'd300, 1'b1);
        in_valid = 1'b0;
        chk("f1_valid",    32'(out_valid), 32'd1);
        chk("f1_sum",      32'(out_sum),   32'd600);
        chk("f1_count",    32'(out_count), 32'd3);
        chk("f1_ovf",      32'(out_ovf),   32'd0);
        chk("f1_in_ready", 32'(in_ready),  32'd0);
        @(negedge clk);
        chk("f1_cleared_valid", 32'(out_valid), 32'd0);
        chk("f1_cleared_ready", 32'(in_ready),  32'd1);

        // 16 x 0xFFFF, auto-close
        for (int i = 0; i < 16; i++) beat(16'hFFFF, 1'b0);
        in_valid = 1'b0;
        chk("max_valid",    32'(out_valid), 32'd1);
        chk("max_sum",      32'(out_sum),   32'd1048560);
        chk("max_count",    32'(out_count), 32'd16);
        chk("max_ovf",      32'(out_ovf),   32'd0);
        chk("max_in_ready", 32'(in_ready),  32'd0);
        @(negedge clk);
        chk("max_bubble_ready", 32'(in_ready),  32'd1);
        chk("max_bubble_valid", 32'(out_valid), 32'd0);

        // in_last on the 16th beat: one close only
        for (int i = 0; i < 16; i++) beat(16'd1, i == 15);
        in_valid = 1'b0;
        chk("last16_sum",   32'(out_sum),   32'd16);
        chk("last16_count", 32'(out_count), 32'd16);
        @(negedge clk);
        @(negedge clk);
        chk("last16_no_empty", 32'(out_valid), 32'd0);

        // ACC_W=17 overflow
        n_valid = 1'b1;
        n_prod  = 16'hFFFF;
        n_last  = 1'b0;
        @(negedge clk);
        @(negedge clk);
        n_last = 1'b1;
        @(negedge clk);
        n_valid = 1'b0;
        chk("ovf17_valid", 32'(n_out_valid), 32'd1);
        chk("ovf17_count", 32'(n_count),     32'd3);
        chk("ovf17_ovf",   32'(n_ovf),       32'd1);
`ifdef PROD_ACCUM_SATURATE_EN
        chk("ovf17_sum",   32'(n_sum),       32'd131071);
`else
        chk("ovf17_sum",   32'(n_sum),       32'd65533);
`endif
        @(negedge clk);

        // Frame {5,7} held with out_ready low while 9 waits upstream
        out_ready = 1'b0;
        beat(16'd5, 1'b0);
        beat(16'd7, 1'b1);
        in_prod = 16'd9;
        in_last = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("hold_in_ready",  32'(in_ready),  32'd0);
            chk("hold_out_valid", 32'(out_valid), 32'd1);
            chk("hold_out_sum",   32'(out_sum),   32'd12);
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("hold_release_ready", 32'(in_ready),  32'd1);
        chk("hold_release_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        in_valid = 1'b0;
        chk("next_valid", 32'(out_valid), 32'd1);
        chk("next_sum",   32'(out_sum),   32'd9);
        chk("next_count", 32'(out_count), 32'd1);
        @(negedge clk);

        // Async reset mid-frame
        beat(16'd10, 1'b0);
        beat(16'd20, 1'b0);
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("arst_sum",   32'(out_sum),   32'd0);
        chk("arst_count", 32'(out_count), 32'd0);
        chk("arst_valid", 32'(out_valid), 32'd0);
        chk("arst_ready", 32'(in_ready),  32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        beat(16'd4, 1'b1);
        in_valid = 1'b0;
        chk("post_rst_valid", 32'(out_valid), 32'd1);
        chk("post_rst_sum",   32'(out_sum),   32'd4);
        chk("post_rst_count", 32'(out_count), 32'd1);
        @(negedge clk);

        // Back-to-back single-beat frames {1},{2},{3}
        in_valid = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            in_prod = 16'(k);
            in_last = 1'b1;
            if (k > 1) begin
                @(negedge clk);
                chk("b2b_bubble_ready", 32'(in_ready),  32'd1);
                chk("b2b_bubble_valid", 32'(out_valid), 32'd0);
            end
            @(negedge clk);
            chk("b2b_valid", 32'(out_valid), 32'd1);
            chk("b2b_sum",   32'(out_sum),   32'(k));
            chk("b2b_count", 32'(out_count), 32'd1);
            chk("b2b_ready", 32'(in_ready),  32'd0);
        end
        in_valid = 1'b0;
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_prod_accum
